// File: rtl/riscv_mem_pkg.sv
// Shared constants for the riscv instruction/data memory responder.
package riscv_mem_pkg;
   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/mem_lane_align.sv
// Lane select with sign/zero extension for loads, lane replication and byte
// enables for stores, and the misalignment decode both paths depend on.
module mem_lane_align
   import riscv_mem_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      lane,
   input  logic [XLEN-1:0] word,
   input  logic [XLEN-1:0] write_data,
   output logic [XLEN-1:0] load_data,
   output logic [XLEN-1:0] store_word,
   output logic [3:0]      byte_en,
   output logic            misaligned
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel   = word[{lane, 3'b000} +: 8];
      half_sel   = word[{lane[1], 4'b0000} +: 16];
      misaligned = ((funct3[1:0] == 2'b01) && lane[0]) ||
                   ((funct3[1:0] == 2'b10) && (lane != 2'b00));

      case (funct3)
         F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
         F3_BU:   load_data = {24'h00_0000, byte_sel};
         F3_HU:   load_data = {16'h0000, half_sel};
         default: load_data = word;
      endcase

      // Store data is replicated across lanes so the enables alone pick the target.
      case (funct3)
         F3_B: begin
            byte_en    = 4'b0001 << lane;
            store_word = {4{write_data[7:0]}};
         end
         F3_H: begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            store_word = {2{write_data[15:0]}};
         end
         F3_W: begin
            byte_en    = 4'b1111;
            store_word = write_data;
         end
         default: begin
            byte_en    = 4'b0000;
            store_word = '0;
         end
      endcase
   end
endmodule

// File: rtl/riscv_mem_model.sv
// Instruction ROM and byte-addressed data RAM responder for the riscv core bench,
// with optional registered reads and a tohost completion mailbox.
module riscv_mem_model
  import riscv_mem_pkg::*;
#(
  parameter int unsigned     IMEM_WORDS  = 256,
  parameter int unsigned     DMEM_WORDS  = 256,
  parameter int unsigned     RD_LAT      = 0,
  parameter string           IMEM_INIT   = "",
  parameter string           DMEM_INIT   = "",
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0400
)(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instruction,
  input  logic            memwrite,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] read_data,
  output logic            misaligned,
  output logic            done,
  output logic            pass,
  output logic [15:0]     store_count
);
  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);
  localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(4 * IMEM_WORDS);
  localparam logic [XLEN-1:0] DMEM_BYTES = XLEN'(4 * DMEM_WORDS);

  logic [XLEN-1:0] imem [IMEM_WORDS];
  logic [XLEN-1:0] dmem [DMEM_WORDS];

  // Preload only; reset never touches array contents.
  initial begin
    for (int unsigned i = 0; i < IMEM_WORDS; i++) imem[i] = NOP;
    for (int unsigned i = 0; i < DMEM_WORDS; i++) dmem[i] = '0;
  end

  logic            i_in_range, d_in_range;
  logic [IAW-1:0]  i_idx;
  logic [DAW-1:0]  d_idx;
  logic [XLEN-1:0] fetch_word, dmem_word, load_data, store_word;
  logic [3:0]      byte_en;
  logic            is_tohost, store_ok, commit_mem;

  assign i_in_range = pc < IMEM_BYTES;
  assign d_in_range = alu_result < DMEM_BYTES;
  assign i_idx      = pc[IAW+1:2];
  assign d_idx      = alu_result[DAW+1:2];
  assign fetch_word = i_in_range ? imem[i_idx] : NOP;
  assign dmem_word  = d_in_range ? dmem[d_idx] : '0;

  mem_lane_align u_align (
    .funct3     (funct3),
    .lane       (alu_result[1:0]),
    .word       (dmem_word),
    .write_data (write_data),
    .load_data  (load_data),
    .store_word (store_word),
    .byte_en    (byte_en),
    .misaligned (misaligned)
  );

  assign is_tohost  = (funct3 == F3_W) && (alu_result == TOHOST_ADDR);
  assign store_ok   = memwrite && !misaligned && !done;
  assign commit_mem = store_ok && d_in_range && !is_tohost && (byte_en != 4'b0000);

  // The array has no reset; a store coincident with reset is dropped explicitly.
  always_ff @(posedge clk) begin
    if (commit_mem && !reset) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) dmem[d_idx][8*b +: 8] <= store_word[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      store_count <= '0;
    end else begin
      if (store_ok && is_tohost) begin
        done <= 1'b1;
        pass <= (write_data == 32'd1);
      end
      if (commit_mem && (store_count != '1)) store_count <= store_count + 16'd1;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_comb_rd
      assign instruction = fetch_word;
      assign read_data   = load_data;
    end else begin : g_reg_rd
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          instruction <= NOP;
          read_data   <= '0;
        end else begin
          instruction <= fetch_word;
          read_data   <= load_data;
        end
      end
    end
  endgenerate
endmodule
